// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: E-stage forwarding, load-use stalls, branch flushes,
// multi-cycle execute stall FSM with timeout, and saturating stall/flush event counters.
module hazard_ctrl_mc #(
  parameter int ADDR_W     = 5,
  parameter int NSRC       = 2,
  parameter int LOAD_LAT   = 1,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RegWriteM,
  input  logic                   RegWriteW,
  input  logic [ADDR_W-1:0]      RD_M,
  input  logic [ADDR_W-1:0]      RD_W,
  input  logic [ADDR_W-1:0]      RDE,
  input  logic                   ResultsrcE0,
  input  logic                   PcsrcE,
  input  logic [NSRC*ADDR_W-1:0] Rs_E,
  input  logic [NSRC*ADDR_W-1:0] Rs_D,
  input  logic                   mc_startE,
  input  logic                   mc_done,
  input  logic                   clr_cnt,
  output logic                   Stall_F,
  output logic                   Stall_D,
  output logic                   Stall_E,
  output logic                   Flush_D,
  output logic                   Flush_E,
  output logic                   Flush_M,
  output logic [NSRC*2-1:0]      ForwardE,
  output logic                   mc_busy,
  output logic                   mc_err,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  localparam int              TMR_W    = $clog2(MC_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);
  localparam logic [1:0]      LD_INIT  = 2'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_e;

  mc_state_e        state_q;
  logic [TMR_W-1:0] timer_q;
  logic             mc_err_q;
  logic [1:0]       ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [NSRC*2-1:0] fwd_s;
  logic              lw_hit_s;
  logic              timeout_s;
  logic              mc_start_s;
  logic              mc_stall_s;
  logic              ld_stall_s;
  logic              stall_f_s;
  logic              flush_d_s;

  // Per-source forward select; the younger M-stage result beats W.
  always_comb begin
    fwd_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (RegWriteM && (RD_M != '0) && (RD_M == Rs_E[i*ADDR_W +: ADDR_W])) begin
        fwd_s[2*i +: 2] = 2'b10;
      end else if (RegWriteW && (RD_W != '0) && (RD_W == Rs_E[i*ADDR_W +: ADDR_W])) begin
        fwd_s[2*i +: 2] = 2'b01;
      end else begin
        fwd_s[2*i +: 2] = 2'b00;
      end
    end
  end

  // Load in E whose destination feeds any D-stage source.
  always_comb begin
    lw_hit_s = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (ResultsrcE0 && (RDE != '0) && (RDE == Rs_D[i*ADDR_W +: ADDR_W])) begin
        lw_hit_s = 1'b1;
      end else begin
        lw_hit_s = lw_hit_s;
      end
    end
  end

  assign timeout_s  = (state_q == ST_BUSY) && (timer_q == TMR_LAST);
  assign mc_start_s = (state_q == ST_IDLE) && mc_startE && !PcsrcE;
  // The mc_done cycle is not stalled: the op leaves E on that edge.
  assign mc_stall_s = mc_start_s || ((state_q == ST_BUSY) && !mc_done && !timeout_s);
  assign ld_stall_s = lw_hit_s || (ld_cnt_q != 2'd0);
  assign stall_f_s  = mc_stall_s || ld_stall_s;
  assign flush_d_s  = PcsrcE;

  // Load-use countdown; a taken branch squashes the load so it is not armed.
  always_comb begin
    if (mc_stall_s) begin
      ld_cnt_d = ld_cnt_q;
    end else if (lw_hit_s && !PcsrcE) begin
      ld_cnt_d = LD_INIT;
    end else if (ld_cnt_q != 2'd0) begin
      ld_cnt_d = ld_cnt_q - 2'd1;
    end else begin
      ld_cnt_d = ld_cnt_q;
    end
  end

  // Saturating event counters; clear beats increment.
  always_comb begin
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      stall_cnt_d = (stall_f_s && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = (flush_d_s && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end
  end

  // Multi-cycle execute FSM with busy timer and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      mc_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mc_start_s) begin
            state_q <= ST_BUSY;
            timer_q <= '0;
          end
        end
        ST_BUSY: begin
          if (mc_done) begin
            state_q <= ST_IDLE;
          end else if (timeout_s) begin
            state_q  <= ST_IDLE;
            mc_err_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  // Load-use counter and event counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_cnt_q    <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ld_cnt_q    <= ld_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Combinational paths are gated so every output reads zero while reset is held.
  assign Stall_F   = rst & stall_f_s;
  assign Stall_D   = rst & stall_f_s;
  assign Stall_E   = rst & mc_stall_s;
  assign Flush_M   = rst & mc_stall_s;
  assign Flush_D   = rst & flush_d_s;
  assign Flush_E   = rst & (PcsrcE | (ld_stall_s & ~mc_stall_s));
  assign ForwardE  = rst ? fwd_s : '0;
  assign mc_busy   = (state_q == ST_BUSY);
  assign mc_err    = mc_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
